tick_gen: RTL and testbench
===========================

TICK_GEN -- requirements
Module: tick_gen

Interface
REQ-001 Parameter DIV_W, default 8: width of divide ratio and prescaler.
REQ-002 Parameter CNT_W, default 16: width of tick_cnt (used only when TICK_GEN_STATUS_EN is defined).
REQ-003 clk  input  1  single clock; all state updates on posedge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 start  input  1  request to begin ticking; sampled only in IDLE.
REQ-006 stop  input  1  abort request; sampled in RUN and in IDLE.
REQ-007 oneshot  input  1  mode select sampled with start: 1 = single tick, 0 = continuous.
REQ-008 div  input  DIV_W  ticks period in cycles; sampled with start.
REQ-009 tick  output  1  one-cycle enable pulse for the downstream counter's count-enable.
REQ-010 busy  output  1  high while in RUN.
REQ-011 done  output  1  one-cycle pulse when a oneshot completes.
REQ-012 tick_cnt  output  CNT_W  number of ticks emitted since last start (present only with TICK_GEN_STATUS_EN).

Function
REQ-013 The FSM SHALL have states IDLE, RUN and DONE, encoded in a 2-bit register.
REQ-014 IDLE->RUN on start=1 and stop=0; div and oneshot latched that edge; prescaler cleared to 0.
REQ-015 div=0 SHALL be latched as 1 (tick every cycle).
REQ-016 In RUN the prescaler increments each cycle; when prescaler == div_lat-1 it wraps to 0 and tick is registered high for the next cycle only.
REQ-017 The first tick SHALL be high exactly div_lat cycles after the edge that accepted start; subsequent ticks every div_lat cycles.
REQ-018 Continuous mode: remain in RUN until stop.
REQ-019 Oneshot mode: on the edge registering the tick, RUN->DONE; done high for one cycle while in DONE; DONE->IDLE on the next edge unconditionally.
REQ-020 stop=1 in RUN: RUN->IDLE next edge; stop SHALL suppress a tick due that same edge; done not asserted.
REQ-021 start and stop both high in IDLE: stop wins, stay IDLE.
REQ-022 start in RUN or DONE SHALL be ignored; div/oneshot changes during RUN SHALL be ignored.
REQ-023 busy SHALL be registered and equal (state==RUN).
REQ-024 tick, done SHALL never be high in the same cycle in continuous mode; in oneshot, tick and done are high together in the DONE cycle.

Reset
REQ-025 rst=1 at posedge: state IDLE, prescaler 0, latched div 1, tick 0, busy 0, done 0, tick_cnt 0.
REQ-026 rst SHALL override start/stop and abort RUN mid-period; no tick or done follows.

Configuration
REQ-027 Macro TICK_GEN_STATUS_EN defined: tick_cnt port exists, cleared on accepted start, increments by 1 on each tick, saturates at all-ones, holds value in IDLE.
REQ-028 Macro undefined: tick_cnt port and its counter are absent; all other behaviour identical.

Structure
REQ-029 Package tick_gen_pkg SHALL hold the state enum (IDLE=0, RUN=1, DONE=2) and default DIV_W/CNT_W constants.
REQ-030 Sub-module tick_prescaler (prescaler counter + wrap compare, outputs wrap strobe) SHALL be used; FSM stays in tick_gen.

Verification
REQ-031 rst high 2 cycles, then low -> tick=0, busy=0, done=0, tick_cnt=0.
REQ-032 div=4, oneshot=0, start 1 cycle -> busy next cycle; ticks 4, 8, 12 cycles after start edge; after 3 ticks tick_cnt=3.
REQ-033 div=3, oneshot=1, start -> one tick at 3 cycles with done high same cycle; busy low; IDLE one cycle later; no further ticks.
REQ-034 div=0, continuous -> tick high every cycle from 1 cycle after start; stop on cycle 5 -> no tick after that edge, busy=0.
REQ-035 start=1, stop=1 in IDLE -> stays IDLE, busy=0; start during RUN with div changed 4->7 -> period stays 4.
REQ-036 div=8 RUN, rst at cycle 5 -> no tick at cycle 8, all outputs 0; with macro, tick_cnt saturation checked at CNT_W=4 (stays 15).

Source files
------------

// File: rtl/tick_gen_pkg.sv
// Shared types and default widths for the tick generator.
package tick_gen_pkg;

    localparam int unsigned DEF_DIV_W = 8;
    localparam int unsigned DEF_CNT_W = 16;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } tick_state_e;

endpackage

// File: rtl/tick_prescaler.sv
// Free-running prescaler with wrap strobe; held at zero while disabled.
module tick_prescaler
    import tick_gen_pkg::*;
#(
    parameter int unsigned DIV_W = DEF_DIV_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [DIV_W-1:0] div_lat,
    output logic             wrap
);

    logic [DIV_W-1:0] cnt;

    // div_lat is never zero, so div_lat-1 cannot underflow.
    always_comb wrap = en && (cnt == div_lat - DIV_W'(1));

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            cnt <= '0;
        end else if (wrap) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/tick_gen.sv
// Tick generator: IDLE/RUN/DONE control around a programmable prescaler.
// Optional TICK_GEN_STATUS_EN adds a saturating tick_cnt status output.
module tick_gen
    import tick_gen_pkg::*;
#(
    parameter int unsigned DIV_W = DEF_DIV_W,
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             oneshot,
    input  logic [DIV_W-1:0] div,
`ifdef TICK_GEN_STATUS_EN
    output logic [CNT_W-1:0] tick_cnt,
`endif
    output logic             tick,
    output logic             busy,
    output logic             done
);

    if (DIV_W == 0 || CNT_W == 0) begin : g_bad_width
        $error("tick_gen: DIV_W and CNT_W must be non-zero");
    end

    tick_state_e      state;
    logic [DIV_W-1:0] div_lat;
    logic             oneshot_lat;
    logic             wrap;
    logic             accept;

    assign accept = (state == StIdle) && start && !stop;

    tick_prescaler #(
        .DIV_W (DIV_W)
    ) u_prescaler (
        .clk     (clk),
        .rst     (rst),
        .en      (state == StRun),
        .div_lat (div_lat),
        .wrap    (wrap)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= StIdle;
            div_lat     <= DIV_W'(1);
            oneshot_lat <= 1'b0;
            tick        <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            tick <= 1'b0;
            done <= 1'b0;
            case (state)
                StIdle: begin
                    if (accept) begin
                        state       <= StRun;
                        busy        <= 1'b1;
                        div_lat     <= (div == '0) ? DIV_W'(1) : div;
                        oneshot_lat <= oneshot;
                    end
                end
                StRun: begin
                    // stop takes priority over a tick due on the same edge
                    if (stop) begin
                        state <= StIdle;
                        busy  <= 1'b0;
                    end else if (wrap) begin
                        tick <= 1'b1;
                        if (oneshot_lat) begin
                            state <= StDone;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                StDone: begin
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef TICK_GEN_STATUS_EN
    always_ff @(posedge clk) begin
        if (rst || accept) begin
            tick_cnt <= '0;
        end else if (state == StRun && !stop && wrap && tick_cnt != '1) begin
            tick_cnt <= tick_cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_tick_gen.sv
// Directed self-checking bench for tick_gen (tick_cnt checks when TICK_GEN_STATUS_EN is set).
module tb_tick_gen;

    localparam int unsigned DIV_W = 8;
`ifdef TICK_GEN_STATUS_EN
    localparam int unsigned CNT_W = 4;
`else
    localparam int unsigned CNT_W = 16;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             stop;
    logic             oneshot;
    logic [DIV_W-1:0] div;
    logic             tick;
    logic             busy;
    logic             done;
`ifdef TICK_GEN_STATUS_EN
    logic [CNT_W-1:0] tick_cnt;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    tick_gen #(
        .DIV_W (DIV_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .stop     (stop),
        .oneshot  (oneshot),
        .div      (div),
`ifdef TICK_GEN_STATUS_EN
        .tick_cnt (tick_cnt),
`endif
        .tick     (tick),
        .busy     (busy),
        .done     (done)
    );

    // Advance n rising edges, then settle 1 time unit past the edge.
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; oneshot = 1'b0; div = '0;

        // Reset
        cyc(2);
        rst = 1'b0;
        cyc(1);
        chk("rst_tick", 32'(tick), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
`ifdef TICK_GEN_STATUS_EN
        chk("rst_cnt", 32'(tick_cnt), 32'd0);
`endif

        // Continuous div=4; restart attempt with div=7 mid-run is ignored
        div = 8'd4; oneshot = 1'b0; start = 1'b1;
        cyc(1);
        start = 1'b0;
        chk("c4_busy", 32'(busy), 32'd1);
        chk("c4_tick0", 32'(tick), 32'd0);
        for (int k = 1; k <= 12; k++) begin
            if (k == 5) begin
                start = 1'b1; div = 8'd7; oneshot = 1'b1;
            end else begin
                start = 1'b0;
            end
            cyc(1);
            chk($sformatf("c4_tick_%0d", k), 32'(tick), (k % 4 == 0) ? 32'd1 : 32'd0);
            chk($sformatf("c4_done_%0d", k), 32'(done), 32'd0);
        end
        oneshot = 1'b0;
`ifdef TICK_GEN_STATUS_EN
        chk("c4_cnt", 32'(tick_cnt), 32'd3);
`endif
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
        chk("c4_stop_busy", 32'(busy), 32'd0);
        chk("c4_stop_tick", 32'(tick), 32'd0);

        // Oneshot div=3
        div = 8'd3; oneshot = 1'b1; start = 1'b1;
        cyc(1);
        start = 1'b0; oneshot = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            cyc(1);
            chk($sformatf("os_tick_%0d", k), 32'(tick), (k == 3) ? 32'd1 : 32'd0);
            chk($sformatf("os_done_%0d", k), 32'(done), (k == 3) ? 32'd1 : 32'd0);
            chk($sformatf("os_busy_%0d", k), 32'(busy), (k < 3) ? 32'd1 : 32'd0);
        end
`ifdef TICK_GEN_STATUS_EN
        chk("os_cnt_hold", 32'(tick_cnt), 32'd1);
`endif

        // div=0 behaves as div=1; stop on cycle 5 suppresses the due tick
        div = 8'd0; start = 1'b1;
        cyc(1);
        start = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            cyc(1);
            chk($sformatf("d0_tick_%0d", k), 32'(tick), 32'd1);
        end
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
        chk("d0_stop_tick", 32'(tick), 32'd0);
        chk("d0_stop_busy", 32'(busy), 32'd0);
        chk("d0_stop_done", 32'(done), 32'd0);
        cyc(2);
        chk("d0_idle_tick", 32'(tick), 32'd0);

        // start and stop together in IDLE: stop wins
        div = 8'd2; start = 1'b1; stop = 1'b1;
        cyc(1);
        chk("ss_busy0", 32'(busy), 32'd0);
        start = 1'b0; stop = 1'b0;
        cyc(2);
        chk("ss_busy1", 32'(busy), 32'd0);
        chk("ss_tick", 32'(tick), 32'd0);

        // div=8, reset asserted on cycle 5 aborts the period
        div = 8'd8; start = 1'b1;
        cyc(1);
        start = 1'b0;
        cyc(4);
        chk("rr_busy_pre", 32'(busy), 32'd1);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        chk("rr_busy", 32'(busy), 32'd0);
        chk("rr_tick", 32'(tick), 32'd0);
        chk("rr_done", 32'(done), 32'd0);
        for (int k = 6; k <= 10; k++) begin
            cyc(1);
            chk($sformatf("rr_tick_%0d", k), 32'(tick), 32'd0);
            chk($sformatf("rr_busyc_%0d", k), 32'(busy), 32'd0);
        end

`ifdef TICK_GEN_STATUS_EN
        // Saturation at CNT_W=4
        div = 8'd1; start = 1'b1;
        cyc(1);
        start = 1'b0;
        cyc(20);
        chk("sat_cnt", 32'(tick_cnt), 32'd15);
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
        cyc(3);
        chk("sat_hold", 32'(tick_cnt), 32'd15);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
